// File: rtl/rob_multi_wb.sv
// Reorder buffer with parametrised depth, multiple writeback ports and in-order multi-retire.
// Optional macro ROB_WB_BYPASS_EN lets same-cycle writebacks make an entry retire-eligible.
module rob_multi_wb #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PRF_W    = 5,
  parameter int unsigned AREG_W   = 3,
  parameter int unsigned WB_PORTS = 2,
  parameter int unsigned RETIRE_W = 2,
  localparam int unsigned ROB_W   = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         freeze,
  input  logic                         alloc_valid,
  input  logic [AREG_W-1:0]            alloc_rw,
  input  logic [PRF_W-1:0]             alloc_tag_prf,
  input  logic [PRF_W-1:0]             alloc_tag_old,
  output logic                         alloc_ready,
  output logic [ROB_W-1:0]             alloc_tag_rob,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*ROB_W-1:0]    wb_tag_rob,
  output logic [RETIRE_W-1:0]          ret_valid,
  output logic [RETIRE_W*AREG_W-1:0]   ret_rw,
  output logic [RETIRE_W*PRF_W-1:0]    ret_tag_prf,
  output logic [RETIRE_W*PRF_W-1:0]    ret_tag_old,
  output logic                         full,
  output logic                         empty,
  output logic [ROB_W:0]               count
);

  localparam int unsigned PTR_W = ROB_W + 1;
  localparam int unsigned RN_W  = $clog2(RETIRE_W + 1);

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0]  wb_hit, done_eff;
  logic [AREG_W-1:0] rw_q      [DEPTH];
  logic [PRF_W-1:0]  tag_prf_q [DEPTH];
  logic [PRF_W-1:0]  tag_old_q [DEPTH];

  logic [RETIRE_W-1:0]        ret_valid_q;
  logic [RETIRE_W*AREG_W-1:0] ret_rw_q;
  logic [RETIRE_W*PRF_W-1:0]  ret_tag_prf_q, ret_tag_old_q;

  logic [ROB_W-1:0]    slot_idx [RETIRE_W];
  logic [RETIRE_W-1:0] ret_mask;
  logic [RN_W-1:0]     ret_n;
  logic                run;
  logic                alloc_fire;
  logic [ROB_W-1:0]    tail_idx;

  assign tail_idx      = tail_q[ROB_W-1:0];
  assign empty         = (head_q == tail_q);
  assign full          = (head_q[ROB_W-1:0] == tail_q[ROB_W-1:0]) &&
                         (head_q[ROB_W] != tail_q[ROB_W]);
  assign count         = tail_q - head_q;
  assign alloc_ready   = !full;
  assign alloc_tag_rob = tail_idx;
  assign alloc_fire    = alloc_valid && !full && !freeze;

  assign ret_valid   = ret_valid_q;
  assign ret_rw      = ret_rw_q;
  assign ret_tag_prf = ret_tag_prf_q;
  assign ret_tag_old = ret_tag_old_q;

  // Duplicate port hits collapse naturally in the OR.
  always_comb begin
    wb_hit = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p]) begin
        wb_hit[wb_tag_rob[p*ROB_W +: ROB_W]] = 1'b1;
      end
    end
  end

`ifdef ROB_WB_BYPASS_EN
  assign done_eff = done_q | (wb_hit & valid_q);
`else
  assign done_eff = done_q;
`endif

  // Leading run of valid+done entries from head, capped by RETIRE_W and occupancy.
  always_comb begin
    ret_n    = '0;
    run      = 1'b1;
    ret_mask = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      slot_idx[k] = head_q[ROB_W-1:0] + ROB_W'(k);
      if (run && !freeze && (PTR_W'(k) < count) &&
          valid_q[slot_idx[k]] && done_eff[slot_idx[k]]) begin
        ret_n       = ret_n + RN_W'(1);
        ret_mask[k] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q | (wb_hit & valid_q);
    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
    end
    for (int k = 0; k < RETIRE_W; k++) begin
      if (ret_mask[k]) begin
        valid_d[slot_idx[k]] = 1'b0;
        done_d[slot_idx[k]]  = 1'b0;
      end
    end
    head_d = head_q + PTR_W'(ret_n);
    tail_d = tail_q + PTR_W'(alloc_fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      valid_q       <= '0;
      done_q        <= '0;
      ret_valid_q   <= '0;
      ret_rw_q      <= '0;
      ret_tag_prf_q <= '0;
      ret_tag_old_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      ret_valid_q <= ret_mask;
      // Non-retiring slots keep their previous payload.
      for (int k = 0; k < RETIRE_W; k++) begin
        if (ret_mask[k]) begin
          ret_rw_q[k*AREG_W +: AREG_W]     <= rw_q[slot_idx[k]];
          ret_tag_prf_q[k*PRF_W +: PRF_W]  <= tag_prf_q[slot_idx[k]];
          ret_tag_old_q[k*PRF_W +: PRF_W]  <= tag_old_q[slot_idx[k]];
        end
      end
    end
  end

  // Payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      rw_q[tail_idx]      <= alloc_rw;
      tag_prf_q[tail_idx] <= alloc_tag_prf;
      tag_old_q[tail_idx] <= alloc_tag_old;
    end
  end

endmodule
